// File: rtl/gpsdo_pkg.sv
// gpsdo_pkg: definitions shared by the GPSDO serial-reporting blocks.
//   uart_state_t      - transmitter frame state encoding
//   UART_IDLE_LVL     - level of the serial line when no frame is in flight
//   calc_clks_per_bit - rounded number of system clocks per UART bit
package gpsdo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

  // Rounded to nearest so the bit period error stays within half a clock.
  function automatic int unsigned calc_clks_per_bit(input int unsigned freq,
                                                    input int unsigned baud);
    return (freq + baud / 32'd2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, shared between UART transmit and receive.
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   clr  in  hold the counter at zero (used while the owner is idle)
//   tick out high on the last clock of each bit period (count == CLKS_PER_BIT-1)
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap after the last count, or hold at zero when cleared.
  always_comb begin
    if (clr || (cnt_q == LAST)) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8-data-bit, no-parity UART transmitter (1 or 2 stop bits), LSB first.
//   CLK_SYS      in  system clock
//   CLK_RST      in  synchronous active-high reset
//   Uart_En      in  send request, acted on at its rising edge only
//   Uart_Data    in  byte to send, sampled in the acceptance cycle
//   Uart_Busy    out high while a frame is in flight
//   Uart_Tx      out serial line, idle high, registered
//   Uart_Ovr     out sticky: a request edge arrived while busy and was dropped
//   Uart_Ovr_Clr in  clears Uart_Ovr (a simultaneous drop wins)
module uart_tx_8n1
  import gpsdo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       CLK_SYS,
  input  logic       CLK_RST,
  input  logic       Uart_En,
  input  logic [7:0] Uart_Data,
  output logic       Uart_Busy,
  output logic       Uart_Tx,
  output logic       Uart_Ovr,
  input  logic       Uart_Ovr_Clr
);

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t state_q, state_d;
  logic        en_q, en_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        req_s;
  logic        baud_tick_s;
  logic        baud_clr_s;

  assign req_s = Uart_En & ~en_q;

  // Every state change out of IDLE or on a tick leaves the counter at zero,
  // so holding it clear in IDLE is enough to restart it on each state entry.
  assign baud_clr_s = (state_q == IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk (CLK_SYS),
    .rst (CLK_RST),
    .clr (baud_clr_s),
    .tick(baud_tick_s)
  );

  // Frame sequencing, shift register and next line level.
  always_comb begin
    en_d      = Uart_En;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        if (req_s) begin
          state_d = START;
          shift_d = Uart_Data;
          tx_d    = 1'b0;
        end else begin
          tx_d = UART_IDLE_LVL;
        end
      end
      START: begin
        if (baud_tick_s) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (baud_tick_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = STOP;
            bit_cnt_d = 3'd0;
            tx_d      = UART_IDLE_LVL;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            // shift_q[1] becomes the LSB after this shift.
            tx_d      = shift_q[1];
          end
        end else begin
          tx_d = shift_q[0];
        end
      end
      STOP: begin
        tx_d = UART_IDLE_LVL;
        if (baud_tick_s) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LVL;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Overrun flag: a dropped request edge sets it and beats a clear.
  always_comb begin
    if (req_s && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (Uart_Ovr_Clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      tx_q      <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign Uart_Tx   = tx_q;
  assign Uart_Busy = busy_q;
  assign Uart_Ovr  = ovr_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// tb_uart_tx_8n1: directed bench for uart_tx_8n1 at 10 clocks per bit.
// dut1 uses one stop bit, dut2 uses two. Inputs change 1 time unit after the
// rising edge and outputs are sampled there too, so "cycle k" is the k-th
// clock after the cycle in which the request edge was sampled.
module tb_uart_tx_8n1;

  logic       clk = 1'b0;
  logic       rst;
  logic       en1, en2, clr1, clr2;
  logic [7:0] data1, data2;
  logic       busy1, busy2, tx1, tx2, ovr1, ovr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_8n1 #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(1)) dut1 (
    .CLK_SYS(clk), .CLK_RST(rst), .Uart_En(en1), .Uart_Data(data1),
    .Uart_Busy(busy1), .Uart_Tx(tx1), .Uart_Ovr(ovr1), .Uart_Ovr_Clr(clr1));

  uart_tx_8n1 #(.CLK_FREQ(1000), .BAUD(100), .STOP_BITS(2)) dut2 (
    .CLK_SYS(clk), .CLK_RST(rst), .Uart_En(en2), .Uart_Data(data2),
    .Uart_Busy(busy2), .Uart_Tx(tx2), .Uart_Ovr(ovr2), .Uart_Ovr_Clr(clr2));

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = i-th bit on the line: [0] start ... [9] stop
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  // Raise Uart_En for one cycle; returns at cycle 1 of the accepted frame.
  task automatic pulse(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      en1 = 1'b1; data1 = d;
    end else begin
      en2 = 1'b1; data2 = d;
    end
    step();
    en1 = 1'b0;
    en2 = 1'b0;
  endtask

  // Check line and busy for cycles 1..len+1; optionally drive a second
  // request edge (with different data) on dut1 at cycle inject_at.
  task automatic check_frame(input int sel, input logic [9:0] frame, input int nstop,
                             input int inject_at, input string nm);
    int len;
    len = (9 + nstop) * 10;
    for (int k = 1; k <= len + 1; k++) begin
      int   idx;
      logic exp_tx;
      idx = (k - 1) / 10;
      if (idx > 9) idx = 9;
      exp_tx = (k <= len) ? frame[idx] : 1'b1;
      chk($sformatf("%s tx c%0d", nm, k), tx_of(sel), exp_tx);
      chk($sformatf("%s busy c%0d", nm, k), busy_of(sel), (k <= len) ? 1'b1 : 1'b0);
      if (inject_at > 0 && k == inject_at) begin
        chk($sformatf("%s ovr before drop", nm), ovr1, 1'b0);
        en1   = 1'b1;
        data1 = 8'hFF;
      end
      if (inject_at > 0 && k == inject_at + 1) begin
        en1 = 1'b0;
        chk($sformatf("%s ovr after drop", nm), ovr1, 1'b1);
      end
      if (k <= len) step();
    end
  endtask

  initial begin
    int frames;
    int busy_cycles;
    logic prev_busy;

    tbl[0] = '{8'hA5, 10'b1_1010_0101_0};
    tbl[1] = '{8'h0D, 10'b1_0000_1101_0};
    tbl[2] = '{8'hFF, 10'b1_1111_1111_0};
    tbl[3] = '{8'h00, 10'b1_0000_0000_0};
    tbl[4] = '{8'h3C, 10'b1_0011_1100_0};

    rst = 1'b1; en1 = 1'b0; en2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    data1 = 8'h00; data2 = 8'h00;
    step(); step(); step();
    chk("reset tx1", tx1, 1'b1);
    chk("reset busy1", busy1, 1'b0);
    chk("reset ovr1", ovr1, 1'b0);
    chk("reset tx2", tx2, 1'b1);
    chk("reset busy2", busy2, 1'b0);
    rst = 1'b0;
    step();

    // Table of single frames, one idle cycle between them.
    for (int i = 0; i < 5; i++) begin
      pulse(0, tbl[i].data);
      check_frame(0, tbl[i].frame, 1, 0, $sformatf("vec%0d", i));
    end
    chk("no ovr after table", ovr1, 1'b0);

    // Uart_En held high: exactly one frame.
    en1 = 1'b1; data1 = 8'hFF;
    frames = 0; busy_cycles = 0; prev_busy = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (busy1) busy_cycles++;
      if (busy1 && !prev_busy) frames++;
      prev_busy = busy1;
    end
    chk("held en frames", frames, 1);
    chk("held en busy cycles", busy_cycles, 100);
    chk("held en ovr", ovr1, 1'b0);
    en1 = 1'b0;
    step();

    // Drop at cycle 40, frame unaffected, clear at cycle 200.
    pulse(0, 8'h0D);
    check_frame(0, 10'b1_0000_1101_0, 1, 40, "drop40");
    for (int k = 101; k < 200; k++) step();
    chk("ovr sticky c200", ovr1, 1'b1);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    chk("ovr cleared c201", ovr1, 1'b0);

    // Drop and clear in the same cycle: set wins; plain clear mid-frame works.
    pulse(0, 8'h11);
    step(); step(); step();
    en1 = 1'b1; clr1 = 1'b1;
    step();
    en1 = 1'b0; clr1 = 1'b0;
    chk("set beats clr", ovr1, 1'b1);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    chk("clr mid-frame", ovr1, 1'b0);
    for (int i = 0; i < 200 && busy1; i++) step();
    chk("frame 0x11 ended", busy1, 1'b0);
    step();

    // Back-to-back: second edge in the first idle cycle.
    pulse(0, 8'h3C);
    check_frame(0, 10'b1_0011_1100_0, 1, 0, "b2b first");
    pulse(0, 8'h00);
    check_frame(0, 10'b1_0000_0000_0, 1, 0, "b2b second");
    chk("b2b ovr", ovr1, 1'b0);

    // Request in the last stop cycle is dropped, not queued.
    pulse(0, 8'hA5);
    check_frame(0, 10'b1_1010_0101_0, 1, 100, "laststop");
    step();
    chk("laststop no frame busy", busy1, 1'b0);
    chk("laststop no frame tx", tx1, 1'b1);

    // Reset at frame cycle 35 with Uart_Ovr set.
    pulse(0, 8'h5A);
    for (int k = 1; k < 35; k++) step();
    chk("pre-reset tx low", tx1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst tx", tx1, 1'b1);
    chk("midrst busy", busy1, 1'b0);
    chk("midrst ovr", ovr1, 1'b0);
    step();
    pulse(0, 8'h5A);
    check_frame(0, 10'b1_0101_1010_0, 1, 0, "after rst");

    // Two stop bits.
    pulse(1, 8'h80);
    check_frame(1, 10'b1_1000_0000_0, 2, 0, "stop2");
    chk("stop2 ovr", ovr2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
